// File: rtl/xpb_table_gen.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_table_gen
//  Purpose  : Builds the table T[j] = (j * B) mod N for j = 0 .. 2^IDX_BITS-1
//             using add-and-conditional-subtract steps, one entry per WRITE.
//             Each entry is handed to an external table RAM through a
//             valid/ready write port.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             start               - request; sampled only while idle
//             base_in, mod_in     - step value B and modulus N (sampled with start)
//             busy, done, err     - status: running / finished pulse / rejected pulse
//             wr_en, wr_addr,     - entry strobe, index and value toward the RAM
//             wr_data, wr_ready     (entry accepted when wr_en && wr_ready)
//  Revision : 1.0 - initial release
// ============================================================================
module xpb_table_gen #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    base_in,
  input  logic [WIDTH-1:0]    mod_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                wr_en,
  output logic [IDX_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]    wr_data,
  input  logic                wr_ready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_ADD   = 3'd2,
    ST_RED   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    b_q,     b_d;
  logic [WIDTH-1:0]    n_q,     n_d;
  logic [WIDTH-1:0]    acc_q,   acc_d;
  logic [WIDTH:0]      sum_q,   sum_d;
  logic [IDX_BITS-1:0] idx_q,   idx_d;
  logic                err_q,   err_d;

  // Operands are legal only if N is nonzero and B is already reduced; this
  // guarantees acc + B < 2N so a single conditional subtract suffices.
  logic w_start_ok;
  assign w_start_ok = (mod_in != '0) && (base_in < mod_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    n_d     = n_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (w_start_ok) begin
            b_d     = base_in;
            n_d     = mod_in;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (wr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ADD;
          end
        end
      end

      ST_ADD: begin
        // Keep the carry so the comparison against N in RED is exact.
        sum_d   = {1'b0, acc_q} + {1'b0, b_q};
        state_d = ST_RED;
      end

      ST_RED: begin
        if (sum_q >= {1'b0, n_q}) begin
          acc_d = WIDTH'(sum_q - {1'b0, n_q});
        end else begin
          acc_d = WIDTH'(sum_q);
        end
        state_d = ST_WRITE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign wr_en   = (state_q == ST_WRITE);
  assign err     = err_q;
  assign wr_addr = idx_q;
  assign wr_data = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_xpb_table_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xpb_table_gen
//  Purpose  : Directed self-checking bench for xpb_table_gen (WIDTH=8,
//             IDX_BITS=5). A negedge monitor logs accepted writes, done/err
//             pulses and stall stability; the main initial block drives the
//             directed sequence and compares the log against (j*B) mod N.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xpb_table_gen;

  localparam int WIDTH    = 8;
  localparam int IDX_BITS = 5;
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int LOG_SZ   = 512;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [WIDTH-1:0]    base_in;
  logic [WIDTH-1:0]    mod_in;
  logic                busy;
  logic                done;
  logic                err;
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                wr_ready;

  xpb_table_gen #(
    .WIDTH    (WIDTH),
    .IDX_BITS (IDX_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_in  (base_in),
    .mod_in   (mod_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int   wr_cnt    = 0;
  int   done_cnt  = 0;
  int   done_cyc  = -1;
  int   err_cnt   = 0;
  int   busy_cnt  = 0;
  int   stall_bad = 0;
  int   log_addr [LOG_SZ];
  int   log_data [LOG_SZ];
  int   log_cyc  [LOG_SZ];
  logic stall_q  = 1'b0;
  logic [IDX_BITS-1:0] st_addr = '0;
  logic [WIDTH-1:0]    st_data = '0;

  always @(negedge clk) begin
    if (wr_en && wr_ready) begin
      if (wr_cnt < LOG_SZ) begin
        log_addr[wr_cnt] = int'(wr_addr);
        log_data[wr_cnt] = int'(wr_data);
        log_cyc[wr_cnt]  = cyc;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (err)  err_cnt  = err_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    if (stall_q && (!wr_en || wr_addr != st_addr || wr_data != st_data))
      stall_bad = stall_bad + 1;
    stall_q = wr_en && !wr_ready;
    st_addr = wr_addr;
    st_data = wr_data;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int b, input int n, output int sc);
    @(posedge clk); #1;
    start   = 1'b1;
    base_in = WIDTH'(b);
    mod_in  = WIDTH'(n);
    sc      = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    // Scramble operands: the run in progress must not see these.
    base_in = 8'hAA;
    mod_in  = 8'h55;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int t = 0;
    while (done_cnt == d0 && t < 1000) begin
      @(posedge clk); #2;
      t++;
    end
    chk({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  task automatic check_table(input int w0, input int b, input int n, input int sc,
                             input bit timing, input string tag);
    chk({tag, "_write_count"}, wr_cnt - w0, ENTRIES);
    for (int j = 0; j < ENTRIES; j++) begin
      int k;
      int a, d, c;
      k = w0 + j;
      a = (k < LOG_SZ) ? log_addr[k] : -1;
      d = (k < LOG_SZ) ? log_data[k] : -1;
      c = (k < LOG_SZ) ? log_cyc[k]  : -1;
      chk($sformatf("%s_addr%0d", tag, j), a, j);
      chk($sformatf("%s_data%0d", tag, j), d, (j * b) % n);
      if (timing) chk($sformatf("%s_cyc%0d", tag, j), c, sc + 1 + 3 * j);
    end
    if (timing) chk({tag, "_done_cycle"}, done_cyc, sc + 95);
  endtask

  initial begin
    int sc, w0, d0, e0, b0, t;
    rst_n    = 1'b0;
    start    = 1'b0;
    base_in  = '0;
    mod_in   = '0;
    wr_ready = 1'b1;

    // ---------------- Reset state ----------------
    #3;
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    chk("rst_err",     err,     0);
    chk("rst_wr_en",   wr_en,   0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ---------------- N=13, B=5, ready always high ----------------
    w0 = wr_cnt; d0 = done_cnt;
    start_run(5, 13, sc);
    wait_done(d0, "runA");
    check_table(w0, 5, 13, sc, 1'b1, "runA");
    chk("runA_idle_after", busy, 0);

    // ---------------- Large modulus with MSB set ----------------
    w0 = wr_cnt; d0 = done_cnt;
    start_run(200, 251, sc);
    wait_done(d0, "runB");
    check_table(w0, 200, 251, sc, 1'b1, "runB");
    chk("runB_entry1_is_B", (w0 + 1 < LOG_SZ) ? log_data[w0 + 1] : -1, 200);

    // Boundary: B = N-1
    w0 = wr_cnt; d0 = done_cnt;
    start_run(127, 128, sc);
    wait_done(d0, "runB2");
    check_table(w0, 127, 128, sc, 1'b1, "runB2");

    // ---------------- Random backpressure with a 20-cycle stall ----------------
    w0 = wr_cnt; d0 = done_cnt;
    start_run(5, 13, sc);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      wr_ready = (t >= 6 && t < 26) ? 1'b0 : 1'(($urandom_range(0, 1)));
      @(posedge clk); #1;
      t++;
    end
    wr_ready = 1'b1;
    chk("runC_done_once", done_cnt - d0, 1);
    check_table(w0, 5, 13, sc, 1'b0, "runC");
    chk("runC_stall_stable", stall_bad, 0);

    // ---------------- Rejected starts ----------------
    e0 = err_cnt; b0 = busy_cnt; w0 = wr_cnt;
    start_run(200, 200, sc);
    repeat (3) @(posedge clk);
    #2;
    chk("err_B_eq_N", err_cnt - e0, 1);
    start_run(5, 0, sc);
    repeat (3) @(posedge clk);
    #2;
    chk("err_N_zero", err_cnt - e0, 2);
    chk("err_busy_never", busy_cnt - b0, 0);
    chk("err_no_writes", wr_cnt - w0, 0);

    // ---------------- start re-pulsed mid-run ----------------
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    start_run(5, 13, sc);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; base_in = 8'd1; mod_in = 8'd7;
    @(posedge clk); #1;
    start = 1'b0; base_in = 8'd200; mod_in = 8'd0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, "runD");
    check_table(w0, 5, 13, sc, 1'b1, "runD");
    chk("runD_no_err", err_cnt - e0, 0);

    // ---------------- Reset mid-run after entry 10 ----------------
    w0 = wr_cnt; d0 = done_cnt;
    start_run(5, 13, sc);
    t = 0;
    while (wr_cnt < w0 + 11 && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    chk("runE_reached_entry10", wr_cnt - w0, 11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("runE_rst_busy",    busy,    0);
    chk("runE_rst_wr_en",   wr_en,   0);
    chk("runE_rst_wr_addr", wr_addr, 0);
    chk("runE_rst_wr_data", wr_data, 0);
    repeat (5) @(posedge clk);
    #2;
    chk("runE_no_done",         done_cnt - d0, 0);
    chk("runE_no_more_writes",  wr_cnt - w0, 11);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    start   = 1'b1;
    base_in = 8'd5;
    mod_in  = 8'd13;
    sc      = cyc;
    w0      = wr_cnt;
    @(posedge clk); #1;
    start   = 1'b0;
    base_in = 8'hAA;
    mod_in  = 8'h55;
    wait_done(d0, "runF");
    check_table(w0, 5, 13, sc, 1'b1, "runF");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
